// File: rtl/execute_stage.sv
// Y86-64 pipeline E register, ALU, condition-code register and cmov/jXX resolution.
// E register and CC share one synchronous active-low reset; bubbles only touch E.
module execute_stage #(
   parameter logic [3:0] RNONE    = 4'hF,
   parameter logic [3:0] STAT_AOK = 4'd1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        E_bubble,
   input  logic [3:0]  d_stat,
   input  logic [3:0]  d_icode,
   input  logic [3:0]  d_ifun,
   input  logic [63:0] d_ValC,
   input  logic [63:0] d_ValA,
   input  logic [63:0] d_ValB,
   input  logic [3:0]  d_dstE,
   input  logic [3:0]  d_dstM,
   input  logic [3:0]  m_stat,
   input  logic [3:0]  W_stat,
   output logic [3:0]  E_stat,
   output logic [3:0]  E_icode,
   output logic [63:0] E_ValA,
   output logic [3:0]  E_dstE,
   output logic [3:0]  E_dstM,
   output logic [63:0] e_ValE,
   output logic [3:0]  e_dstE,
   output logic        e_Cnd,
   output logic        ZF,
   output logic        SF,
   output logic        OF
);

   localparam logic [3:0] INOP    = 4'h1;
   localparam logic [3:0] IRRMOVQ = 4'h2;
   localparam logic [3:0] IIRMOVQ = 4'h3;
   localparam logic [3:0] IRMMOVQ = 4'h4;
   localparam logic [3:0] IMRMOVQ = 4'h5;
   localparam logic [3:0] IOPQ    = 4'h6;
   localparam logic [3:0] ICALL   = 4'h8;
   localparam logic [3:0] IRET    = 4'h9;
   localparam logic [3:0] IPUSHQ  = 4'hA;
   localparam logic [3:0] IPOPQ   = 4'hB;

   logic [3:0]  stat_q, stat_d, icode_q, icode_d, ifun_q, ifun_d;
   logic [3:0]  dste_q, dste_d, dstm_q, dstm_d;
   logic [63:0] valc_q, valc_d, vala_q, vala_d, valb_q, valb_d;
   logic        zf_q, zf_d, sf_q, sf_d, of_q, of_d;

   logic [63:0] alu_a, alu_b, alu_res;
   logic        alu_of, set_cc, cnd, lt;

   always_comb begin
      alu_a = 64'd0;
      case (icode_q)
         IRRMOVQ, IOPQ:             alu_a = vala_q;
         IIRMOVQ, IRMMOVQ, IMRMOVQ: alu_a = valc_q;
         ICALL, IPUSHQ:             alu_a = 64'hFFFF_FFFF_FFFF_FFF8;
         IRET, IPOPQ:               alu_a = 64'd8;
         default:                   alu_a = 64'd0;
      endcase
      alu_b = 64'd0;
      case (icode_q)
         IRMMOVQ, IMRMOVQ, IOPQ, ICALL, IRET, IPUSHQ, IPOPQ: alu_b = valb_q;
         default:                                            alu_b = 64'd0;
      endcase
   end

   // Non-OPq instructions always add; OF only matters when set_cc is true.
   always_comb begin
      alu_res = alu_b + alu_a;
      alu_of  = (alu_a[63] == alu_b[63]) && (alu_res[63] != alu_b[63]);
      if (icode_q == IOPQ) begin
         case (ifun_q)
            4'd1: begin
               alu_res = alu_b - alu_a;
               alu_of  = (alu_a[63] != alu_b[63]) && (alu_res[63] != alu_b[63]);
            end
            4'd2: begin
               alu_res = alu_b & alu_a;
               alu_of  = 1'b0;
            end
            4'd3: begin
               alu_res = alu_b ^ alu_a;
               alu_of  = 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign set_cc = (icode_q == IOPQ) && (m_stat == STAT_AOK) && (W_stat == STAT_AOK);

   // Condition is resolved from the committed CC, not the flags in flight.
   always_comb begin
      lt  = sf_q ^ of_q;
      cnd = 1'b0;
      case (ifun_q)
         4'd0:    cnd = 1'b1;
         4'd1:    cnd = lt | zf_q;
         4'd2:    cnd = lt;
         4'd3:    cnd = zf_q;
         4'd4:    cnd = ~zf_q;
         4'd5:    cnd = ~lt;
         4'd6:    cnd = ~lt & ~zf_q;
         default: cnd = 1'b0;
      endcase
   end

   always_comb begin
      stat_d  = d_stat;
      icode_d = d_icode;
      ifun_d  = d_ifun;
      valc_d  = d_ValC;
      vala_d  = d_ValA;
      valb_d  = d_ValB;
      dste_d  = d_dstE;
      dstm_d  = d_dstM;
      if (!rst_n || E_bubble) begin
         stat_d  = STAT_AOK;
         icode_d = INOP;
         ifun_d  = 4'd0;
         valc_d  = 64'd0;
         vala_d  = 64'd0;
         valb_d  = 64'd0;
         dste_d  = RNONE;
         dstm_d  = RNONE;
      end
      zf_d = zf_q;
      sf_d = sf_q;
      of_d = of_q;
      if (!rst_n) begin
         zf_d = 1'b1;
         sf_d = 1'b0;
         of_d = 1'b0;
      end else if (set_cc) begin
         zf_d = (alu_res == 64'd0);
         sf_d = alu_res[63];
         of_d = alu_of;
      end
   end

   always_ff @(posedge clk) begin
      stat_q  <= stat_d;
      icode_q <= icode_d;
      ifun_q  <= ifun_d;
      valc_q  <= valc_d;
      vala_q  <= vala_d;
      valb_q  <= valb_d;
      dste_q  <= dste_d;
      dstm_q  <= dstm_d;
      zf_q    <= zf_d;
      sf_q    <= sf_d;
      of_q    <= of_d;
   end

   assign E_stat  = stat_q;
   assign E_icode = icode_q;
   assign E_ValA  = vala_q;
   assign E_dstE  = dste_q;
   assign E_dstM  = dstm_q;
   assign e_ValE  = alu_res;
   assign e_Cnd   = cnd;
   assign e_dstE  = (icode_q == IRRMOVQ && !cnd) ? RNONE : dste_q;
   assign ZF      = zf_q;
   assign SF      = sf_q;
   assign OF      = of_q;

endmodule

// File: tb/tb_execute_stage.sv
// Bench for execute_stage: directed plan with literal expectations, then random traffic
// compared every cycle against an instruction-level model of the E stage.
module tb_execute_stage;

   logic        clk = 1'b0;
   logic        rst_n, E_bubble;
   logic [3:0]  d_stat, d_icode, d_ifun, d_dstE, d_dstM, m_stat, W_stat;
   logic [63:0] d_ValC, d_ValA, d_ValB;
   logic [3:0]  E_stat, E_icode, E_dstE, E_dstM, e_dstE;
   logic [63:0] E_ValA, e_ValE;
   logic        e_Cnd, ZF, SF, OF;

   int n_vec = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   execute_stage dut (
      .clk(clk), .rst_n(rst_n), .E_bubble(E_bubble),
      .d_stat(d_stat), .d_icode(d_icode), .d_ifun(d_ifun), .d_ValC(d_ValC),
      .d_ValA(d_ValA), .d_ValB(d_ValB), .d_dstE(d_dstE), .d_dstM(d_dstM),
      .m_stat(m_stat), .W_stat(W_stat),
      .E_stat(E_stat), .E_icode(E_icode), .E_ValA(E_ValA), .E_dstE(E_dstE),
      .E_dstM(E_dstM), .e_ValE(e_ValE), .e_dstE(e_dstE), .e_Cnd(e_Cnd),
      .ZF(ZF), .SF(SF), .OF(OF)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: what each instruction class computes, in plain arithmetic.
   function automatic void model_alu(input logic [3:0] icode, input logic [3:0] ifun,
                                     input logic [63:0] a, input logic [63:0] b,
                                     input logic [63:0] c, output logic [63:0] val,
                                     output logic ovf);
      logic signed [64:0] wide;
      val = 64'd0;
      ovf = 1'b0;
      case (icode)
         4'h2:       val = a;
         4'h3:       val = c;
         4'h4, 4'h5: val = b + c;
         4'h8, 4'hA: val = b - 64'd8;
         4'h9, 4'hB: val = b + 64'd8;
         4'h6: begin
            case (ifun)
               4'd1: begin
                  wide = $signed({b[63], b}) - $signed({a[63], a});
                  val  = wide[63:0];
                  ovf  = wide[64] != wide[63];
               end
               4'd2: val = a & b;
               4'd3: val = a ^ b;
               default: begin
                  wide = $signed({b[63], b}) + $signed({a[63], a});
                  val  = wide[63:0];
                  ovf  = wide[64] != wide[63];
               end
            endcase
         end
         default: val = 64'd0;
      endcase
   endfunction

   function automatic logic model_cnd(input logic [3:0] ifun, input logic zf, input logic sf,
                                      input logic ovf);
      logic less;
      less = (sf != ovf);
      case (ifun)
         4'd0:    return 1'b1;
         4'd1:    return less || zf;
         4'd2:    return less;
         4'd3:    return zf;
         4'd4:    return !zf;
         4'd5:    return !less;
         4'd6:    return !less && !zf;
         default: return 1'b0;
      endcase
   endfunction

   logic [3:0]  r_stat, r_icode, r_ifun, r_dste, r_dstm;
   logic [63:0] r_valc, r_vala, r_valb;
   logic        r_zf, r_sf, r_of;
   logic [63:0] exp_val;
   logic        exp_of, exp_cnd;
   logic [3:0]  exp_dste;

   always_comb begin
      exp_val = 64'd0;
      exp_of  = 1'b0;
      model_alu(r_icode, r_ifun, r_vala, r_valb, r_valc, exp_val, exp_of);
      exp_cnd  = model_cnd(r_ifun, r_zf, r_sf, r_of);
      exp_dste = (r_icode == 4'h2 && !exp_cnd) ? 4'hF : r_dste;
   end

   always @(posedge clk) begin
      if (!rst_n) begin
         r_zf <= 1'b1; r_sf <= 1'b0; r_of <= 1'b0;
      end else if (r_icode == 4'h6 && m_stat == 4'd1 && W_stat == 4'd1) begin
         r_zf <= (exp_val == 64'd0); r_sf <= exp_val[63]; r_of <= exp_of;
      end
      if (!rst_n || E_bubble) begin
         r_stat <= 4'd1; r_icode <= 4'h1; r_ifun <= 4'd0; r_valc <= 64'd0;
         r_vala <= 64'd0; r_valb <= 64'd0; r_dste <= 4'hF; r_dstm <= 4'hF;
      end else begin
         r_stat <= d_stat; r_icode <= d_icode; r_ifun <= d_ifun; r_valc <= d_ValC;
         r_vala <= d_ValA; r_valb <= d_ValB; r_dste <= d_dstE; r_dstm <= d_dstM;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("E_stat", E_stat, r_stat);
         check("E_icode", E_icode, r_icode);
         check("E_ValA", E_ValA, r_vala);
         check("E_dstE", E_dstE, r_dste);
         check("E_dstM", E_dstM, r_dstm);
         check("e_ValE", e_ValE, exp_val);
         check("e_dstE", e_dstE, exp_dste);
         check("e_Cnd", e_Cnd, exp_cnd);
         check("ZF", ZF, r_zf);
         check("SF", SF, r_sf);
         check("OF", OF, r_of);
      end
   end

   task automatic drive(input logic [3:0] icode, input logic [3:0] ifun, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] c, input logic [3:0] dste);
      d_stat = 4'd1; d_icode = icode; d_ifun = ifun; d_ValA = a; d_ValB = b; d_ValC = c;
      d_dstE = dste; d_dstM = 4'hF;
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic logic [63:0] rnd64();
      case ($urandom_range(0, 5))
         0:       return 64'd0;
         1:       return 64'hFFFF_FFFF_FFFF_FFFF;
         2:       return 64'h7FFF_FFFF_FFFF_FFFF;
         3:       return 64'h8000_0000_0000_0000;
         4:       return 64'($urandom_range(0, 20));
         default: return {$urandom, $urandom};
      endcase
   endfunction

   initial begin
      rst_n = 1'b0; E_bubble = 1'b0; m_stat = 4'd1; W_stat = 4'd1;
      d_stat = 4'd1; d_icode = 4'h1; d_ifun = 4'd0; d_ValA = 64'd0; d_ValB = 64'd0;
      d_ValC = 64'd0; d_dstE = 4'hF; d_dstM = 4'hF;
      @(posedge clk);
      chk_en = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("rst E_icode", E_icode, 64'h1);
      check("rst E_dstE", E_dstE, 64'hF);
      check("rst E_dstM", E_dstM, 64'hF);
      check("rst E_stat", E_stat, 64'h1);
      check("rst ZF", ZF, 64'h1);
      check("rst SF", SF, 64'h0);
      check("rst OF", OF, 64'h0);
      check("rst e_ValE", e_ValE, 64'h0);
      rst_n = 1'b1;

      drive(4'h6, 4'd1, 64'd5, 64'd3, 64'd0, 4'h2);
      check("sub e_ValE", e_ValE, 64'hFFFF_FFFF_FFFF_FFFE);
      drive(4'h2, 4'd1, 64'd9, 64'd0, 64'd0, 4'h3);
      check("sub ZF", ZF, 64'h0);
      check("sub SF", SF, 64'h1);
      check("sub OF", OF, 64'h0);
      check("cmovle cnd", e_Cnd, 64'h1);
      check("cmovle dstE", e_dstE, 64'h3);
      drive(4'h2, 4'd3, 64'd9, 64'd0, 64'd0, 4'h3);
      check("cmove cnd", e_Cnd, 64'h0);
      check("cmove dstE", e_dstE, 64'hF);

      drive(4'h6, 4'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 4'h2);
      check("add e_ValE", e_ValE, 64'hFFFF_FFFF_FFFF_FFFE);
      drive(4'h1, 4'd0, 64'd0, 64'd0, 64'd0, 4'hF);
      check("add SF", SF, 64'h1);
      check("add OF", OF, 64'h1);
      check("add ZF", ZF, 64'h0);

      m_stat = 4'd3;
      drive(4'h6, 4'd3, 64'h1234, 64'h1234, 64'd0, 4'h2);
      check("xor e_ValE", e_ValE, 64'h0);
      drive(4'h1, 4'd0, 64'd0, 64'd0, 64'd0, 4'hF);
      check("m_stat block ZF", ZF, 64'h0);
      m_stat = 4'd1; W_stat = 4'd2;
      drive(4'h6, 4'd3, 64'h55, 64'h55, 64'd0, 4'h2);
      drive(4'h1, 4'd0, 64'd0, 64'd0, 64'd0, 4'hF);
      check("W_stat block ZF", ZF, 64'h0);
      check("W_stat block OF", OF, 64'h1);
      W_stat = 4'd1;

      E_bubble = 1'b1;
      drive(4'hA, 4'd0, 64'd7, 64'd100, 64'd0, 4'h4);
      check("bubble E_icode", E_icode, 64'h1);
      check("bubble E_dstE", E_dstE, 64'hF);
      check("bubble SF", SF, 64'h1);
      rst_n = 1'b0;
      drive(4'hA, 4'd0, 64'd7, 64'd100, 64'd0, 4'h4);
      check("bubble+rst ZF", ZF, 64'h1);
      check("bubble+rst SF", SF, 64'h0);
      rst_n = 1'b1; E_bubble = 1'b0;
      drive(4'h8, 4'd0, 64'd0, 64'd256, 64'd0, 4'h4);
      check("call e_ValE", e_ValE, 64'd248);
      check("call e_dstE", e_dstE, 64'h4);

      for (int i = 0; i < 2000; i++) begin
         rst_n    = ($urandom_range(0, 49) != 0);
         E_bubble = ($urandom_range(0, 9) == 0);
         m_stat   = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 4)) : 4'd1;
         W_stat   = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 4)) : 4'd1;
         d_stat   = 4'($urandom_range(1, 4));
         d_icode  = ($urandom_range(0, 2) == 0) ? 4'h6 : 4'($urandom_range(0, 15));
         d_ifun   = (d_icode == 4'h6) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 8));
         d_ValA   = rnd64();
         d_ValB   = rnd64();
         d_ValC   = rnd64();
         d_dstE   = 4'($urandom_range(0, 15));
         d_dstM   = 4'($urandom_range(0, 15));
         @(posedge clk);
         @(negedge clk);
      end

      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
